// File: rtl/add8_char_pkg.sv
// ============================================================================
// Module      : add8_char_pkg
// Description : Shared widths, FSM state encoding and saturating add helper
//               for the add8 approximate-adder characterization monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add8_char_pkg;

    localparam int c_W     = 8;
    localparam int c_CNT_W = 17;
    localparam int c_SAE_W = c_CNT_W + c_W + 1;
    localparam int c_SSE_W = c_CNT_W + 2 * (c_W + 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Returns {sum, overflow}; sum is clamped to all-ones of the given width.
    function automatic logic [64:0] sat_add(
        input logic [63:0] acc,
        input logic [63:0] inc,
        input int          width
    );
        logic [64:0] sum;
        logic [63:0] lim;
        lim = (64'd1 << width) - 64'd1;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, lim}) begin
            return {lim, 1'b1};
        end
        return {sum[63:0], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/add8_err_calc.sv
// ============================================================================
// Module      : add8_err_calc
// Description : Second pipeline stage: exact sum, signed error, |error| and
//               |error|^2, registered with a flushable valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add8_err_calc
    import add8_char_pkg::*;
#(
    parameter int W = c_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W:0]     o,
    output logic           out_valid,
    output logic [W:0]     abs_err,
    output logic [2*W+1:0] sq_err
);

    logic [W:0]     w_exact;
    logic [W+1:0]   w_diff;
    logic [W+1:0]   w_neg;
    logic [W:0]     w_abs;
    logic [2*W+1:0] w_sq;

    logic           r_valid;
    logic [W:0]     r_abs;
    logic [2*W+1:0] r_sq;

    assign w_exact = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, o} - {1'b0, w_exact};
    assign w_neg   = -w_diff;
    // |diff| never exceeds 2^(W+1)-1, so the sign bit can be dropped.
    assign w_abs   = w_diff[W+1] ? w_neg[W:0] : w_diff[W:0];
    assign w_sq    = (2*W+2)'(w_abs) * (2*W+2)'(w_abs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_abs   <= '0;
            r_sq    <= '0;
        end else begin
            r_valid <= in_valid & ~flush;
            if (in_valid) begin
                r_abs <= w_abs;
                r_sq  <= w_sq;
            end
        end
    end

    assign out_valid = r_valid;
    assign abs_err   = r_abs;
    assign sq_err    = r_sq;

endmodule

`default_nettype wire

// File: rtl/add8_err_monitor.sv
// ============================================================================
// Module      : add8_err_monitor
// Description : Captures approximate-adder samples, accumulates saturating
//               error statistics per burst and presents one report per burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add8_err_monitor
    import add8_char_pkg::*;
#(
    parameter int W     = c_W,
    parameter int CNT_W = c_CNT_W,
    parameter int SAE_W = CNT_W + W + 1,
    parameter int SSE_W = CNT_W + 2 * (W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W:0]       in_o,
    input  logic             in_last,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic [CNT_W-1:0] samples,
    output logic [SAE_W-1:0] sum_abs_err,
    output logic [SSE_W-1:0] sum_sq_err,
    output logic [W:0]       max_err,
    output logic [CNT_W-1:0] err_count,
    output logic             sat
);

    state_t r_state, w_state_nxt;

    logic             w_accept, w_stat_hs;
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_a, r_s1_b;
    logic [W:0]       r_s1_o;
    logic             w_s2_valid;
    logic [W:0]       w_s2_abs;
    logic [2*W+1:0]   w_s2_sq;

    logic [CNT_W-1:0] r_samples, r_err_count;
    logic [SAE_W-1:0] r_sum_abs;
    logic [SSE_W-1:0] r_sum_sq;
    logic [W:0]       r_max_err;
    logic             r_sat;

    logic [64:0]      w_samples_add, w_sae_add, w_sse_add, w_errc_add;
    logic             w_any_ovf;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        stat_valid  = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = ~clr & ~rst;
                if (w_accept && in_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!r_s1_valid && !w_s2_valid) w_state_nxt = REPORT;
            end
            REPORT: begin
                stat_valid = 1'b1;
                if (stat_ready) w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clr) w_state_nxt = ACCUM;
    end

    assign w_accept  = in_valid & in_ready;
    assign w_stat_hs = stat_valid & stat_ready;

    // S1: clr forces in_ready low, so no sample enters during a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_o     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= in_a;
                r_s1_b <= in_b;
                r_s1_o <= in_o;
            end
        end
    end

    add8_err_calc #(
        .W (W)
    ) u_calc (
        .clk       (clk),
        .rst       (rst),
        .flush     (clr),
        .in_valid  (r_s1_valid),
        .a         (r_s1_a),
        .b         (r_s1_b),
        .o         (r_s1_o),
        .out_valid (w_s2_valid),
        .abs_err   (w_s2_abs),
        .sq_err    (w_s2_sq)
    );

    assign w_samples_add = sat_add(64'(r_samples), 64'd1, CNT_W);
    assign w_sae_add     = sat_add(64'(r_sum_abs), 64'(w_s2_abs), SAE_W);
    assign w_sse_add     = sat_add(64'(r_sum_sq), 64'(w_s2_sq), SSE_W);
    assign w_errc_add    = sat_add(64'(r_err_count), {63'd0, (w_s2_abs != '0)}, CNT_W);

    // Bits above each accumulator width are zero after clamping.
    assign w_any_ovf = w_samples_add[0] | (|w_samples_add[64:CNT_W+1])
                     | w_sae_add[0]     | (|w_sae_add[64:SAE_W+1])
                     | w_sse_add[0]     | (|w_sse_add[64:SSE_W+1])
                     | w_errc_add[0]    | (|w_errc_add[64:CNT_W+1]);

    always_ff @(posedge clk) begin
        if (rst || clr || w_stat_hs) begin
            r_samples   <= '0;
            r_sum_abs   <= '0;
            r_sum_sq    <= '0;
            r_max_err   <= '0;
            r_err_count <= '0;
            r_sat       <= 1'b0;
        end else if (w_s2_valid) begin
            r_samples   <= w_samples_add[CNT_W:1];
            r_sum_abs   <= w_sae_add[SAE_W:1];
            r_sum_sq    <= w_sse_add[SSE_W:1];
            r_err_count <= w_errc_add[CNT_W:1];
            r_max_err   <= (w_s2_abs > r_max_err) ? w_s2_abs : r_max_err;
            r_sat       <= r_sat | w_any_ovf;
        end
    end

    assign samples     = r_samples;
    assign sum_abs_err = r_sum_abs;
    assign sum_sq_err  = r_sum_sq;
    assign max_err     = r_max_err;
    assign err_count   = r_err_count;
    assign sat         = r_sat;

endmodule

`default_nettype wire
